// File: rtl/calc_result_reader.sv
// Reads the processor's signed result word and converts its magnitude to 10 BCD digits plus sign
// (double dabble, one bit per clock). Define RESULT_STATUS_POLL_EN to poll the done flag first.
module calc_result_reader #(
  parameter logic [31:0] RESULT_ADDR = 32'd28
`ifdef RESULT_STATUS_POLL_EN
  , parameter logic [31:0] STATUS_ADDR = 32'd32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        leaResult,
  output logic [31:0] address,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [39:0] result_bcd,
  output logic        result_neg,
  output logic        result_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef RESULT_STATUS_POLL_EN
    POLL,
    PAUSE,
`endif
    READ,
    ABS,
    CONV,
    DONE
  } state_t;

  state_t      state, state_n;
  logic        lea_q;
  logic        start;
  logic [4:0]  cnt;
  logic [31:0] mag;
  logic        neg_pend;
  logic [39:0] bcd_sr;
  logic [39:0] bcd_adj;
  logic [71:0] shift_n;

  assign start        = leaResult & ~lea_q;
  assign busy         = (state != IDLE) && (state != DONE);
  assign result_valid = (state == DONE);
`ifdef RESULT_STATUS_POLL_EN
  assign mem_rd       = (state == POLL) || (state == READ);
`else
  assign mem_rd       = (state == READ);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef RESULT_STATUS_POLL_EN
          state_n = POLL;
`else
          state_n = READ;
`endif
        end
      end
`ifdef RESULT_STATUS_POLL_EN
      POLL:  if (mem_ack) state_n = mem_rdata[0] ? READ : PAUSE;
      PAUSE: state_n = POLL;
`endif
      READ:  if (mem_ack) state_n = ABS;
      ABS:   state_n = CONV;
      CONV:  if (cnt == 5'd31) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Each double-dabble step: correct every nibble >= 5, then shift one magnitude bit in.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 10; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    shift_n = {bcd_adj, mag} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lea_q      <= 1'b0;
      address    <= 32'd0;
      result_bcd <= 40'd0;
      result_neg <= 1'b0;
      cnt        <= 5'd0;
      mag        <= 32'd0;
      neg_pend   <= 1'b0;
      bcd_sr     <= 40'd0;
    end else begin
      lea_q <= leaResult;
      if (state_n == READ) address <= RESULT_ADDR;
`ifdef RESULT_STATUS_POLL_EN
      if (state_n == POLL) address <= STATUS_ADDR;
`endif
      case (state)
        READ: if (mem_ack) mag <= mem_rdata;
        ABS: begin
          neg_pend <= mag[31];
          mag      <= mag[31] ? (~mag + 32'd1) : mag;
          bcd_sr   <= 40'd0;
          cnt      <= 5'd0;
        end
        CONV: begin
          bcd_sr <= shift_n[71:32];
          mag    <= shift_n[31:0];
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_bcd <= shift_n[71:32];
            result_neg <= neg_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_reader.sv
// Self-checking bench for calc_result_reader: spec-level behavioural model with a per-cycle
// compare process, a reactive memory responder, and directed vectors with literal expectations.
module tb_calc_result_reader;

  logic        clk;
  logic        rst;
  logic        leaResult;
  logic [31:0] address;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [39:0] result_bcd;
  logic        result_neg;
  logic        result_valid;
  logic        busy;

  calc_result_reader dut (
    .clk(clk), .rst(rst), .leaResult(leaResult),
    .address(address), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .result_bcd(result_bcd), .result_neg(result_neg),
    .result_valid(result_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected BCD computed with plain decimal arithmetic on the two's-complement magnitude.
  function automatic logic [39:0] to_bcd(input logic [31:0] w);
    longint m;
    logic [39:0] r;
    m = longint'({32'd0, w});
    if (w[31]) m = 64'sd4294967296 - m;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Memory responder
  logic [31:0] result_word = 32'd0;
  int          ack_delay = 0;
  bit          spur = 1'b0;
  logic [31:0] status_q[$];
  int          resp_result_acks = 0;
  int          resp_status_acks = 0;
  int          wait_cnt = 0;
  logic [31:0] req_addr = 32'd0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_rd) begin
        if (wait_cnt == 0) req_addr = address;
        else checkOutput("addr_stable", {32'd0, address}, {32'd0, req_addr});
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (address == 32'd28) begin
            mem_rdata = result_word;
            resp_result_acks++;
          end else begin
            mem_rdata = (status_q.size() > 0) ? status_q.pop_front() : 32'd1;
            resp_status_acks++;
          end
        end
        wait_cnt++;
      end else begin
        if (wait_cnt > 0) checkOutput("mem_rd_held", {63'd0, mem_rd}, 64'd1);
        wait_cnt = 0;
        if (spur) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hDEADBEEF;
          spur      = 1'b0;
        end
      end
    end
  end

  // Behavioural model of the visible protocol
  localparam int P_IDLE = 0, P_POLL = 1, P_PAUSE = 2, P_READ = 3, P_CONV = 4;
  int          m_phase = P_IDLE;
  bit          m_lea = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  logic [39:0] m_bcd = '0;
  bit          m_neg = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_word = '0;
  int          m_cd = 0;

  always @(posedge clk) begin
    bit st;
    if (rst) begin
      m_phase = P_IDLE; m_lea = 0; m_busy = 0; m_valid = 0;
      m_bcd = '0; m_neg = 0; m_addr = '0;
    end else begin
      st = leaResult && !m_lea;
      m_lea = leaResult;
      case (m_phase)
        P_IDLE: if (st) begin
          m_valid = 0;
          m_busy  = 1;
`ifdef RESULT_STATUS_POLL_EN
          m_phase = P_POLL; m_addr = 32'd32;
`else
          m_phase = P_READ; m_addr = 32'd28;
`endif
        end
        P_POLL: if (mem_ack) begin
          if (mem_rdata[0]) begin m_phase = P_READ; m_addr = 32'd28; end
          else m_phase = P_PAUSE;
        end
        P_PAUSE: m_phase = P_POLL;
        P_READ: if (mem_ack) begin m_word = mem_rdata; m_cd = 33; m_phase = P_CONV; end
        P_CONV: begin
          m_cd--;
          if (m_cd == 0) begin
            m_bcd = to_bcd(m_word); m_neg = m_word[31];
            m_valid = 1; m_busy = 0; m_phase = P_IDLE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("busy", {63'd0, busy}, {63'd0, m_busy});
      checkOutput("result_valid", {63'd0, result_valid}, {63'd0, m_valid});
      checkOutput("result_bcd", {24'd0, result_bcd}, {24'd0, m_bcd});
      checkOutput("result_neg", {63'd0, result_neg}, {63'd0, m_neg});
      checkOutput("mem_rd", {63'd0, mem_rd}, {63'd0, (m_phase == P_POLL || m_phase == P_READ)});
      checkOutput("address", {32'd0, address}, {32'd0, m_addr});
    end
  end

  // Drive a one-cycle start pulse; called at a negedge, returns at the negedge after edge s.
  task automatic applyStimulus(input logic [31:0] word, input int delay);
    result_word = word;
    ack_delay   = delay;
    leaResult   = 1'b1;
    @(negedge clk);
    leaResult   = 1'b0;
  endtask

  task automatic waitValid(output int n);
    bit seen = 1'b0;
    n = 1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    if (!seen) checkOutput("timeout_valid", 64'd0, 64'd1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_valid"}, {63'd0, result_valid}, 64'd0);
    checkOutput({tag, "_mem_rd"}, {63'd0, mem_rd}, 64'd0);
    checkOutput({tag, "_addr"}, {32'd0, address}, 64'd0);
    checkOutput({tag, "_bcd"}, {24'd0, result_bcd}, 64'd0);
    checkOutput({tag, "_neg"}, {63'd0, result_neg}, 64'd0);
  endtask

  initial begin
    int n;
    int acks0;
    rst = 1'b1;
    leaResult = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    cmp_en = 1'b1;

    applyStimulus(32'h0000007B, 0);
    waitValid(n);
`ifndef RESULT_STATUS_POLL_EN
    checkOutput("latency_edges", 64'(n), 64'd35);
`endif
    checkOutput("bcd_123", {24'd0, result_bcd}, 64'h0000000123);
    checkOutput("neg_123", {63'd0, result_neg}, 64'd0);
    checkOutput("addr_result", {32'd0, address}, 64'd28);

    applyStimulus(32'hFFFFFF85, 0);
    waitValid(n);
    checkOutput("bcd_m123", {24'd0, result_bcd}, 64'h0000000123);
    checkOutput("neg_m123", {63'd0, result_neg}, 64'd1);

    applyStimulus(32'h80000000, 0);
    waitValid(n);
    checkOutput("bcd_min", {24'd0, result_bcd}, 64'h2147483648);
    checkOutput("neg_min", {63'd0, result_neg}, 64'd1);

    applyStimulus(32'h00BC614E, 5);
    waitValid(n);
    checkOutput("bcd_delay", {24'd0, result_bcd}, 64'h0012345678);

    acks0 = resp_result_acks;
    applyStimulus(32'h00003039, 0);
    repeat (12) @(negedge clk);
    checkOutput("mid_old_bcd", {24'd0, result_bcd}, 64'h0012345678);
    checkOutput("mid_valid", {63'd0, result_valid}, 64'd0);
    checkOutput("mid_busy", {63'd0, busy}, 64'd1);
    leaResult = 1'b1;
    spur = 1'b1;
    @(negedge clk);
    leaResult = 1'b0;
    waitValid(n);
    checkOutput("bcd_12345", {24'd0, result_bcd}, 64'h0000012345);
    checkOutput("one_read_conv_edge", 64'(resp_result_acks - acks0), 64'd1);

    applyStimulus(32'h000003E7, 0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkReset("midreset");
    rst = 1'b0;
    applyStimulus(32'h000003E7, 0);
    waitValid(n);
`ifndef RESULT_STATUS_POLL_EN
    checkOutput("latency_after_rst", 64'(n), 64'd35);
`endif
    checkOutput("bcd_999", {24'd0, result_bcd}, 64'h0000000999);

    acks0 = resp_result_acks;
    result_word = 32'h0000002A;
    ack_delay = 0;
    leaResult = 1'b1;
    repeat (50) @(negedge clk);
    leaResult = 1'b0;
    @(negedge clk);
    checkOutput("hold_one_read", 64'(resp_result_acks - acks0), 64'd1);
    checkOutput("hold_valid", {63'd0, result_valid}, 64'd1);
    checkOutput("bcd_42", {24'd0, result_bcd}, 64'h0000000042);

`ifdef RESULT_STATUS_POLL_EN
    acks0 = resp_status_acks;
    status_q.push_back(32'd0);
    status_q.push_back(32'd0);
    status_q.push_back(32'd1);
    applyStimulus(32'hFFFFFFFF, 0);
    waitValid(n);
    checkOutput("poll_count", 64'(resp_status_acks - acks0), 64'd3);
    checkOutput("bcd_m1", {24'd0, result_bcd}, 64'h0000000001);
    checkOutput("neg_m1", {63'd0, result_neg}, 64'd1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
